pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Front-end program counter sequencer for a pipelined core. It chooses the next
// fetch address from the branch, jump-register and jump redirect requests,
// falling back to PC+4. A redirect requested while fetch cannot advance is
// parked in a pending register and applied on the next advance. A halt freezes
// the sequencer until reset.
//
// Ports
//   CLK        : clock, all state updates on the rising edge
//   RST        : synchronous active-high reset
//   ihit       : fetch of the current PC completes this cycle
//   stall      : hazard unit holds the front end
//   halt       : halt instruction decoded
//   br_taken   : EX-stage branch resolved taken, target on br_target
//   jr_en      : EX-stage jump-register, target on jr_target
//   j_en       : ID-stage J/JAL, target on JumpAddr
//   PC         : current fetch address
//   imemREN    : instruction memory read enable
//   flush_ifid : squash IF/ID (cycle a redirect is applied)
//   flush_idex : squash ID/EX (cycle an EX-class redirect is applied)
//   halted     : sequencer is halted
//   misalign   : sticky, some applied redirect target had bits [1:0] != 0
//   redir_cnt  : saturating count of applied redirects
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        j_en,
    input  logic [31:0] JumpAddr,
    output logic [31:0] PC,
    output logic        imemREN,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] redir_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        PEND = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t        state_r;
    logic [31:0]   pc_r;
    logic [31:0]   pend_tgt_r;
    logic          pend_ex_r;
    logic          halted_r;
    logic          misalign_r;
    logic [15:0]   cnt_r;

    logic          adv_s;
    logic          ex_req_s;
    logic          any_req_s;
    logic [31:0]   ex_tgt_s;
    logic [31:0]   req_tgt_s;
    logic          apply_s;
    logic          apply_ex_s;
    logic [31:0]   apply_tgt_s;
    logic          seq_s;

    // Redirect targets are always word aligned when loaded into the PC.
    function automatic logic [31:0] align_tgt(input logic [31:0] tgt);
        return {tgt[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] tgt);
        return (tgt[1:0] != 2'b00);
    endfunction

    // Request decode, target selection and the "redirect applied this cycle" strobe.
    always_comb begin
        adv_s       = ihit & ~stall & (state_r != HALT);
        ex_req_s    = br_taken | jr_en;
        any_req_s   = ex_req_s | j_en;
        ex_tgt_s    = br_taken ? br_target : jr_target;
        apply_s     = 1'b0;
        apply_ex_s  = 1'b0;
        apply_tgt_s = 32'h0000_0000;
        seq_s       = 1'b0;

        if (ex_req_s) begin
            req_tgt_s = ex_tgt_s;
        end else begin
            req_tgt_s = JumpAddr;
        end

        case (state_r)
            RUN: begin
                // halt outranks every redirect, so nothing is applied on a halt cycle
                apply_s     = adv_s & ~halt & any_req_s;
                apply_ex_s  = ex_req_s;
                apply_tgt_s = req_tgt_s;
                seq_s       = adv_s & ~halt & ~any_req_s;
            end
            PEND: begin
                // live requests are ignored in the cycle the parked one is applied
                apply_s     = adv_s & ~halt;
                apply_ex_s  = pend_ex_r;
                apply_tgt_s = pend_tgt_r;
                seq_s       = 1'b0;
            end
            default: begin
                apply_s     = 1'b0;
                apply_ex_s  = 1'b0;
                apply_tgt_s = 32'h0000_0000;
                seq_s       = 1'b0;
            end
        endcase
    end

    // Output decode; reset masks the flushes and keeps fetch enabled.
    always_comb begin
        flush_ifid = apply_s & ~RST;
        flush_idex = apply_s & apply_ex_s & ~RST;
        imemREN    = RST | (state_r != HALT);
        PC         = pc_r;
        halted     = halted_r;
        misalign   = misalign_r;
        redir_cnt  = cnt_r;
    end

    // Sequencer FSM with PC, pending redirect and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RUN;
            pc_r       <= PC_INIT;
            pend_tgt_r <= 32'h0000_0000;
            pend_ex_r  <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= 1'b0;
            cnt_r      <= 16'h0000;
        end else begin
            if (apply_s) begin
                pc_r <= align_tgt(apply_tgt_s);
                if (is_misaligned(apply_tgt_s)) begin
                    misalign_r <= 1'b1;
                end
                if (cnt_r != 16'hFFFF) begin
                    cnt_r <= cnt_r + 16'd1;
                end
            end else if (seq_s) begin
                pc_r <= pc_r + 32'd4;
            end

            case (state_r)
                RUN: begin
                    if (halt) begin
                        state_r    <= HALT;
                        halted_r   <= 1'b1;
                        pend_tgt_r <= 32'h0000_0000;
                        pend_ex_r  <= 1'b0;
                    end else if (~adv_s & any_req_s) begin
                        pend_tgt_r <= req_tgt_s;
                        pend_ex_r  <= ex_req_s;
                        state_r    <= PEND;
                    end
                end
                PEND: begin
                    if (halt) begin
                        state_r    <= HALT;
                        halted_r   <= 1'b1;
                        pend_tgt_r <= 32'h0000_0000;
                        pend_ex_r  <= 1'b0;
                    end else if (adv_s) begin
                        state_r    <= RUN;
                        pend_tgt_r <= 32'h0000_0000;
                        pend_ex_r  <= 1'b0;
                    end else if (ex_req_s) begin
                        // a newer EX redirect supersedes whatever was parked
                        pend_tgt_r <= ex_tgt_s;
                        pend_ex_r  <= 1'b1;
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    // unreachable encoding: freeze until reset
                    state_r  <= HALT;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic        stall;
    logic        halt;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        j_en;
    logic [31:0] JumpAddr;
    logic [31:0] PC;
    logic        imemREN;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;
    logic        misalign;
    logic [15:0] redir_cnt;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt(halt),
        .br_taken(br_taken), .br_target(br_target),
        .jr_en(jr_en), .jr_target(jr_target),
        .j_en(j_en), .JumpAddr(JumpAddr),
        .PC(PC), .imemREN(imemREN), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halted(halted), .misalign(misalign), .redir_cnt(redir_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, ihit, stall, halt, br;
        logic [31:0] brt;
        logic        jr;
        logic [31:0] jrt;
        logic        j;
        logic [31:0] ja;
        logic        fi, fx, ren;     // expected before the edge
        logic [31:0] pc;              // expected after the edge
        logic        mis;
        logic [15:0] cnt;
        logic        hlt;
    } vec_t;

    typedef struct {
        logic [31:0] tgt;
        bit          ex;
    } pend_t;

    vec_t        vecs[$];

    // reference model state
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_mis;
    logic [15:0] m_cnt;
    pend_t       m_pend[$];
    bit          m_fi, m_fx, m_ren;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ih, input logic st, input logic hl,
                         input logic b, input logic [31:0] bt, input logic jr,
                         input logic [31:0] jrt, input logic j, input logic [31:0] ja);
        RST = r; ihit = ih; stall = st; halt = hl;
        br_taken = b; br_target = bt; jr_en = jr; jr_target = jrt; j_en = j; JumpAddr = ja;
    endtask

    task automatic m_apply(input logic [31:0] tgt);
        m_pc = tgt & 32'hFFFF_FFFC;
        if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    // Advance the reference model by one clock using the currently driven inputs;
    // also produces the expected same-cycle flush/read-enable values.
    task automatic m_step();
        bit          adv;
        bit          req;
        logic [31:0] tgt;
        pend_t       p;
        adv   = ihit && !stall && !m_halted;
        m_fi  = 1'b0;
        m_fx  = 1'b0;
        m_ren = RST || !m_halted;
        if (RST) begin
            m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
            m_pend.delete();
        end else if (m_halted) begin
            m_pc = m_pc;
        end else if (halt) begin
            m_halted = 1'b1;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            if (adv) begin
                m_fi = 1'b1;
                m_fx = m_pend[0].ex;
                m_apply(m_pend[0].tgt);
                m_pend.delete();
            end else if (br_taken || jr_en) begin
                m_pend[0].tgt = br_taken ? br_target : jr_target;
                m_pend[0].ex  = 1'b1;
            end
        end else begin
            req = br_taken || jr_en || j_en;
            tgt = br_taken ? br_target : (jr_en ? jr_target : JumpAddr);
            if (adv && req) begin
                m_fi = 1'b1;
                m_fx = br_taken || jr_en;
                m_apply(tgt);
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end else if (req) begin
                p.tgt = tgt;
                p.ex  = br_taken || jr_en;
                m_pend.push_back(p);
            end
        end
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(9) == 0) t = 32'hFFFF_FFFC;
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        //           rst   ihit  stall halt  br    brt           jr    jrt           j     ja              fi    fx    ren   pc             mis   cnt       hlt
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h100,      1'b1, 1'b0, 1'b1, 32'h100,      1'b0, 16'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h0040_0020,1'b1, 1'b0, 1'b1, 32'h0040_0020,1'b0, 16'd2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h200,      1'b1, 1'b0, 1'b1, 32'h200,      1'b0, 16'd3, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300,     1'b0, 32'h0,       1'b1, 32'h500,      1'b1, 1'b1, 1'b1, 32'h300,      1'b0, 16'd4, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h40,       1'b1, 1'b0, 1'b1, 32'h40,       1'b0, 16'd5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h80,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 16'd5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 16'd5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 16'd5, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 16'd6, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h103,     1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h100,      1'b1, 16'd7, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h200,      1'b1, 1'b0, 1'b1, 32'h200,      1'b1, 16'd8, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h400,     1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 16'd8, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h600,      1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 16'd8, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h700,     1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 16'd8, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h900,     1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h700,      1'b1, 16'd9, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h800,      1'b0, 1'b0, 1'b1, 32'h700,      1'b1, 16'd9, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h700,      1'b1, 16'd9, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10,      1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h700,      1'b1, 16'd9, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'hFFFF_FFFC,1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC,1'b0, 16'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 16'd1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h44,       1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 16'd1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 16'd0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 16'd0, 1'b0});

        // directed table
        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].ihit, vecs[i].stall, vecs[i].halt, vecs[i].br, vecs[i].brt,
                  vecs[i].jr, vecs[i].jrt, vecs[i].j, vecs[i].ja);
            #1;
            check($sformatf("vec%0d flush_ifid", i), {31'h0, flush_ifid}, {31'h0, vecs[i].fi});
            check($sformatf("vec%0d flush_idex", i), {31'h0, flush_idex}, {31'h0, vecs[i].fx});
            check($sformatf("vec%0d imemREN", i),    {31'h0, imemREN},    {31'h0, vecs[i].ren});
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d PC", i),        PC,                  vecs[i].pc);
            check($sformatf("vec%0d misalign", i),  {31'h0, misalign},   {31'h0, vecs[i].mis});
            check($sformatf("vec%0d redir_cnt", i), {16'h0, redir_cnt},  {16'h0, vecs[i].cnt});
            check($sformatf("vec%0d halted", i),    {31'h0, halted},     {31'h0, vecs[i].hlt});
        end

        // randomized run against the reference model, starting from reset
        m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            drive((c == 0) || ($urandom_range(99) < 2),
                  $urandom_range(99) < 70,
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 3,
                  $urandom_range(99) < 20, rnd_tgt(),
                  $urandom_range(99) < 15, rnd_tgt(),
                  $urandom_range(99) < 20, rnd_tgt());
            m_step();
            #1;
            check("rnd flush_ifid", {31'h0, flush_ifid}, {31'h0, m_fi});
            check("rnd flush_idex", {31'h0, flush_idex}, {31'h0, m_fx});
            check("rnd imemREN",    {31'h0, imemREN},    {31'h0, m_ren});
            @(posedge CLK);
            #1;
            check("rnd PC",        PC,                 m_pc);
            check("rnd misalign",  {31'h0, misalign},  {31'h0, m_mis});
            check("rnd redir_cnt", {16'h0, redir_cnt}, {16'h0, m_cnt});
            check("rnd halted",    {31'h0, halted},    {31'h0, m_halted});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
